// File: rtl/hazard_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard controller.
//   fwd_sel_t     : EX operand mux select (regfile / EX-MEM ALU_Out / MEM-WB result)
//   stage_entry_t : per-stage record of source/destination registers and flags
//   eff_write     : does an entry really write a register someone could depend on
//   dest_only     : strip an entry down to what the MEM and WB stages need
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int ENTRY_REG_W  = 5;
   localparam int ZERO_REG_IDX = 31;

   localparam int NUM_STAGES = 3;
   localparam int STAGE_EX   = 0;
   localparam int STAGE_MEM  = 1;
   localparam int STAGE_WB   = 2;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic                   valid;
      logic [ENTRY_REG_W-1:0] rn;
      logic [ENTRY_REG_W-1:0] rm;
      logic                   use_rn;
      logic                   use_rm;
      logic [ENTRY_REG_W-1:0] rd;
      logic                   reg_write;
      logic                   mem_read;
   } stage_entry_t;

   // A write to XZR is discarded by the register file, so it can never be a
   // hazard source or a forwarding source.
   function automatic logic eff_write(input stage_entry_t e,
                                      input logic [ENTRY_REG_W-1:0] zero_reg);
      return e.valid & e.reg_write & (e.rd != zero_reg);
   endfunction

   // Downstream of EX only the destination side of an instruction matters.
   function automatic stage_entry_t dest_only(input stage_entry_t e);
      stage_entry_t r;
      r           = '0;
      r.valid     = e.valid;
      r.rd        = e.rd;
      r.reg_write = e.reg_write;
      return r;
   endfunction

endpackage

// File: rtl/hazard_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hazard_stage
// One pipeline-stage record of the hazard controller.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low clear of the entry
//   bubble : synchronous; load an empty entry instead of d on this edge
//   d      : entry arriving from the previous stage
//   q      : registered entry
// -----------------------------------------------------------------------------
module hazard_stage
   import hazard_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         bubble,
   input  stage_entry_t d,
   output stage_entry_t q
);

   stage_entry_t entry_q;
   stage_entry_t entry_d;

   always_comb begin
      entry_d = d;
      if (bubble) begin
         entry_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign q = entry_q;

endmodule

// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hazard_ctrl
// Feedback half of the pipeline control path. Tracks destination register and
// write/load flags of the instructions in EX, MEM and WB and drives operand
// forwarding selects, the load-use stall and branch flush/bubble controls.
//
// Ports
//   clk, reset           : rising-edge clock, asynchronous active-low reset
//   id_*                 : decoded instruction currently in ID
//   ex_brTaken           : EX instruction resolved as a taken branch
//   stall                : hold PC and IF/ID
//   flush_ifid           : clear IF/ID to NOP
//   ex_bubble            : load zeros into ID/EX this edge
//   fwdA, fwdB           : EX operand selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall_cnt, flush_cnt : saturating event counters
//
// Build option: define HAZARD_PERF_EN to implement the stall/flush counters;
// otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = ENTRY_REG_W,
   parameter int ZERO_REG   = ZERO_REG_IDX
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_Rn,
   input  logic [REG_ADDR_W-1:0] id_Rm,
   input  logic                  id_useRn,
   input  logic                  id_useRm,
   input  logic [REG_ADDR_W-1:0] id_Rd,
   input  logic                  id_RegWrite,
   input  logic                  id_MemRead,
   input  logic                  ex_brTaken,
   output logic                  stall,
   output logic                  flush_ifid,
   output logic                  ex_bubble,
   output logic [1:0]            fwdA,
   output logic [1:0]            fwdB,
   output logic [15:0]           stall_cnt,
   output logic [15:0]           flush_cnt
);

   localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

   stage_entry_t           id_entry;
   stage_entry_t           stage_d [NUM_STAGES];
   stage_entry_t           stage_q [NUM_STAGES];
   logic [NUM_STAGES-1:0]  stage_bubble;

   stage_entry_t ex_e;
   stage_entry_t mem_e;
   stage_entry_t wb_e;

   logic     mem_eff;
   logic     wb_eff;
   logic     load_use;
   logic     bubble_now;
   fwd_sel_t fwd_a_sel;
   fwd_sel_t fwd_b_sel;

   // A non-valid ID slot becomes an all-zero entry so it can never match.
   always_comb begin
      id_entry = '0;
      if (id_valid) begin
         id_entry.valid     = 1'b1;
         id_entry.rn        = id_Rn;
         id_entry.rm        = id_Rm;
         id_entry.use_rn    = id_useRn;
         id_entry.use_rm    = id_useRm;
         id_entry.rd        = id_Rd;
         id_entry.reg_write = id_RegWrite;
         id_entry.mem_read  = id_MemRead;
      end
   end

   // Only the EX entry can be bubbled; MEM and WB always advance so a stalled
   // load keeps moving toward writeback.
   assign stage_bubble = {{(NUM_STAGES-1){1'b0}}, bubble_now};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         if (gi == STAGE_EX) begin : g_src
            assign stage_d[gi] = id_entry;
         end else begin : g_src
            assign stage_d[gi] = dest_only(stage_q[gi-1]);
         end

         hazard_stage u_stage (
            .clk    (clk),
            .reset  (reset),
            .bubble (stage_bubble[gi]),
            .d      (stage_d[gi]),
            .q      (stage_q[gi])
         );
      end
   endgenerate

   assign ex_e  = stage_q[STAGE_EX];
   assign mem_e = stage_q[STAGE_MEM];
   assign wb_e  = stage_q[STAGE_WB];

   always_comb begin
      mem_eff = eff_write(mem_e, ZERO_IDX);
      wb_eff  = eff_write(wb_e,  ZERO_IDX);

      // The younger producer (MEM) holds the newer value and wins over WB.
      fwd_a_sel = FWD_RF;
      if (ex_e.use_rn && mem_eff && (mem_e.rd == ex_e.rn)) begin
         fwd_a_sel = FWD_MEM;
      end else if (ex_e.use_rn && wb_eff && (wb_e.rd == ex_e.rn)) begin
         fwd_a_sel = FWD_WB;
      end

      fwd_b_sel = FWD_RF;
      if (ex_e.use_rm && mem_eff && (mem_e.rd == ex_e.rm)) begin
         fwd_b_sel = FWD_MEM;
      end else if (ex_e.use_rm && wb_eff && (wb_e.rd == ex_e.rm)) begin
         fwd_b_sel = FWD_WB;
      end

      // Load data is only available after MEM, so a consumer directly behind
      // a load must wait one cycle.
      load_use = id_valid & ex_e.valid & ex_e.mem_read & ex_e.reg_write
               & (ex_e.rd != ZERO_IDX)
               & ((id_useRn & (id_Rn == ex_e.rd)) | (id_useRm & (id_Rm == ex_e.rd)));

      // A taken branch squashes the ID instruction, so its load-use hazard
      // is irrelevant and no stall is raised.
      flush_ifid = ex_brTaken;
      stall      = load_use & ~ex_brTaken;
      bubble_now = ex_brTaken | load_use;
   end

   assign ex_bubble = bubble_now;
   assign fwdA      = fwd_a_sel;
   assign fwdB      = fwd_b_sel;

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;
   logic [15:0] flush_cnt_q;
   logic [15:0] flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (ex_brTaken && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = 16'd0;
   assign flush_cnt = 16'd0;
`endif

   // MEM and WB keep only the destination side; their source fields are
   // constant zero and deliberately unread.
   logic unused_fields;
   assign unused_fields = ^{mem_e.rn, mem_e.rm, mem_e.use_rn, mem_e.use_rm, mem_e.mem_read,
                            wb_e.rn,  wb_e.rm,  wb_e.use_rn,  wb_e.use_rm,  wb_e.mem_read};

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Feedback half of the pipelined datapath's control path. The control-register chain pushes ALUOp, MemWrite, MemRead, xferByte, MemToReg and RegWrite forward through ID/EX, EX/MEM and MEM/WB.
- This block runs the other way: it keeps its own per-stage record of destination register and write/load flags.
- From that record it drives back into the pipeline: forwarding selects for the EX operand muxes, a load-use stall, and branch flush/bubble controls.
- Sits beside the control-register chain; inputs come from ID decode and EX branch resolve.

Parameters:
- REG_ADDR_W, 5, register-index width.
- ZERO_REG, 31, index of XZR; never a hazard, never forwarded.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; low clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_Rn  in  REG_ADDR_W  first source register.
- id_Rm  in  REG_ADDR_W  second source register.
- id_useRn  in  1  instruction reads Rn.
- id_useRm  in  1  instruction reads Rm.
- id_Rd  in  REG_ADDR_W  destination register.
- id_RegWrite  in  1  instruction writes Rd.
- id_MemRead  in  1  instruction is a load.
- ex_brTaken  in  1  EX instruction resolved as a taken branch.
- stall  out  1  hold PC and IF/ID.
- flush_ifid  out  1  clear IF/ID to NOP.
- ex_bubble  out  1  control-register chain loads zeros into ID/EX this edge.
- fwdA  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU_Out, 10 MEM/WB result.
- fwdB  out  2  EX operand B select, same encoding.
- stall_cnt  out  16  load-use stall count (optional feature).
- flush_cnt  out  16  branch flush count (optional feature).

Behaviour:
- State: three entries, EX, MEM and WB. Each holds {valid, Rn, Rm, useRn, useRm, Rd, RegWrite, MemRead}. MEM and WB only need {valid, Rd, RegWrite}.
- Reset (reset=0, asynchronous): all entries invalid, all other fields 0. Outputs: stall=0, flush_ifid=0, ex_bubble=0, fwdA=fwdB=00, counters 0.
- Effective write: valid & RegWrite & Rd!=ZERO_REG. An entry without it matches nothing.
- Normal advance, every rising edge: WB<=MEM, MEM<=EX, EX<=ID inputs, where the ID fields are gated by id_valid.
- Forwarding is combinational from registered state, in the same cycle as the EX instruction:
  - fwdA=01 if the MEM entry has an effective write and MEM.Rd==EX.Rn & EX.useRn.
  - else fwdA=10 if the WB entry matches the same way.
  - else fwdA=00.
  - MEM beats WB when both match. fwdB uses Rm/useRm identically.
- Load-use hazard (combinational):
  - EX.valid & EX.MemRead & EX.RegWrite & EX.Rd!=ZERO_REG, and
  - (id_useRn & id_Rn==EX.Rd) or (id_useRm & id_Rm==EX.Rd), and id_valid.
- Outputs per cycle, in priority order:
  - ex_brTaken=1: flush_ifid=1, ex_bubble=1, stall=0. EX entry loads a bubble (valid=0). The load-use check is ignored because the ID instruction is squashed.
  - else load-use hazard: stall=1, ex_bubble=1. EX entry loads a bubble. The ID instruction stays in place and is re-evaluated next cycle.
  - else: stall=0, ex_bubble=0, flush_ifid=0.
- Load-use stall lasts exactly one cycle per load. Next cycle the load is in MEM, so the hazard clears and the dependent instruction gets fwd=10 one cycle later.
- Back-to-back loads, each feeding the next: each stalls one cycle independently.
- Reset deasserted mid-stream: the first post-reset cycle sees empty entries, so no forwarding and no stall.
- Widths: all compares are REG_ADDR_W bits. No arithmetic except the optional counters.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments on each cycle with a load-use stall.
  - flush_cnt increments on each cycle with ex_brTaken.
  - Both are 16-bit, saturate at 16'hFFFF and clear on reset.
- Undefined: no counter flops; stall_cnt and flush_cnt tied to 0. Ports remain for a stable interface.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10}.
  - Constant ZERO_REG_IDX=31.
  - Packed struct stage_entry_t for the entry fields.
- Sub-module hazard_stage: one entry flop with async active-low clear and a synchronous bubble input. Instantiated for EX, MEM and WB.

Test Plan:
- Reset asserted low mid-stream with entries valid -> all outputs 0 immediately (asynchronous); after release, ADD X3 then SUB X4,X3,X5 still forwards (fwdA=01).
- ADD X1,X2,X3 then SUB X4,X1,X5 -> with SUB in EX: fwdA=01, fwdB=00, stall=0.
- ADD X1, NOP, ORR X6,X7,X1 -> with ORR in EX: fwdB=10. Also ADD X1; ADD X1; SUB using X1 -> fwdA=01 (MEM beats WB).
- LDUR X2,[X0] then ADD X9,X2,X2 -> stall=1 and ex_bubble=1 for exactly one cycle; next cycle stall=0; ADD in EX sees fwdA=fwdB=10. With HAZARD_PERF_EN, stall_cnt=1.
- ex_brTaken=1 while a load-use hazard is present -> flush_ifid=1, ex_bubble=1, stall=0; the flushed instruction never forwards.
- ADD XZR (Rd=31) then SUB X4,X31,X31 -> fwdA=fwdB=00. LDUR XZR then a use of X31 -> stall=0.
